// File: rtl/nucleotide_pkg.sv
// nucleotide_pkg -- shared definitions for the nucleotide encoder.
// Holds the 2-bit symbol codes, the FIFO depth and the pointer/count widths.
// Button bit index equals the symbol code (A=0, C=1, G=2, T=3), so a one-hot
// press vector encodes directly to its code.
package nucleotide_pkg;

  typedef enum logic [1:0] {
    NUC_A = 2'b00,
    NUC_C = 2'b01,
    NUC_G = 2'b10,
    NUC_T = 2'b11
  } nuc_code_t;

  localparam int FIFO_DEPTH = 4;
  localparam int PTR_W      = 2;
  localparam int CNT_W      = 3;

  // One-hot button vector to code; only meaningful when exactly one bit is set.
  function automatic logic [1:0] onehot_to_code(input logic [3:0] oh);
    logic [1:0] code;
    code = NUC_A;
    if (oh[1]) code = NUC_C;
    if (oh[2]) code = NUC_G;
    if (oh[3]) code = NUC_T;
    return code;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// sync_edge -- 2-flop synchronizer followed by a previous-value register and
// a rising-edge detector for one button level.
// Ports:
//   i_w_clk     system clock
//   i_w_reset   async active-high reset; all flops reset to 1 so a button
//               held through reset release never looks like a new press
//   i_w_btn     asynchronous button level
//   o_w_level   synchronized level (second synchronizer flop)
//   o_w_event   one-cycle press event: level=1 while previous value=0
module sync_edge (
  input  logic i_w_clk,
  input  logic i_w_reset,
  input  logic i_w_btn,
  output logic o_w_level,
  output logic o_w_event
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge i_w_clk or posedge i_w_reset) begin
    if (i_w_reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= i_w_btn;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign o_w_level = sync2;
  assign o_w_event = sync2 & ~prev;

endmodule

// File: rtl/nucleotide_encoder.sv
// nucleotide_encoder -- turns four debounced button levels (A, C, G, T) into a
// stream of 2-bit nucleotide codes held in a 4-entry FIFO.
// Ports:
//   i_w_clk, i_w_reset    clock and async active-high reset
//   i_w_A/G/C/T           debounced button levels
//   i_w_ready             downstream accepts the head symbol this cycle
//   o_r_valid             FIFO non-empty
//   o_r_code              head symbol (00 when empty)
//   o_r_error             one-cycle pulse on an illegal press
//   o_r_overflow          sticky: a symbol was dropped on a full FIFO
//   o_r_count             FIFO occupancy 0..4
//
// Handshake: the head symbol is transferred on a rising clock edge where
// o_r_valid=1 and i_w_ready=1; o_r_code is stable while o_r_valid=1 and not
// popped, and ready with an empty FIFO has no effect.
module nucleotide_encoder
  import nucleotide_pkg::*;
(
  input  logic       i_w_clk,
  input  logic       i_w_reset,
  input  logic       i_w_A,
  input  logic       i_w_G,
  input  logic       i_w_C,
  input  logic       i_w_T,
  input  logic       i_w_ready,
  output logic       o_r_valid,
  output logic [1:0] o_r_code,
  output logic       o_r_error,
  output logic       o_r_overflow,
  output logic [2:0] o_r_count
);

  // Bit index == symbol code.
  logic [3:0] btn;
  logic [3:0] level;
  logic [3:0] evt;

  assign btn = {i_w_T, i_w_G, i_w_C, i_w_A};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    sync_edge u_sync_edge (
      .i_w_clk   (i_w_clk),
      .i_w_reset (i_w_reset),
      .i_w_btn   (btn[i]),
      .o_w_level (level[i]),
      .o_w_event (evt[i])
    );
  end

  // Legal: exactly one event and no other button is held (the pressing
  // button's own level is necessarily 1, so level must equal evt).
  logic evt_onehot;
  logic press_legal;
  logic press_illegal;

  assign evt_onehot    = (evt != 4'b0000) && ((evt & (evt - 4'd1)) == 4'b0000);
  assign press_legal   = evt_onehot && (level == evt);
  assign press_illegal = (evt != 4'b0000) && !press_legal;

  // FIFO state
  logic [1:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             error_q;
  logic             overflow_q;

  logic full;
  logic do_pop;
  logic do_push;
  logic drop;

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign do_pop  = (count != '0) && i_w_ready;
  // A pop on the same edge frees a slot, so a full FIFO still accepts.
  assign do_push = press_legal && (!full || do_pop);
  assign drop    = press_legal && full && !do_pop;

  always_ff @(posedge i_w_clk or posedge i_w_reset) begin
    if (i_w_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      error_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      error_q <= press_illegal;
      if (drop) overflow_q <= 1'b1;
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: it is only observed through a non-zero count.
  always_ff @(posedge i_w_clk) begin
    if (do_push) mem[wr_ptr] <= onehot_to_code(evt);
  end

  assign o_r_valid    = (count != '0);
  assign o_r_code     = o_r_valid ? mem[rd_ptr] : NUC_A;
  assign o_r_error    = error_q;
  assign o_r_overflow = overflow_q;
  assign o_r_count    = count;

endmodule

// File: tb/tb_nucleotide_encoder.sv
module tb_nucleotide_encoder;

  logic       clk;
  logic       rst;
  logic       btn_a, btn_g, btn_c, btn_t;
  logic       ready;
  logic       valid;
  logic [1:0] code;
  logic       error;
  logic       overflow;
  logic [2:0] count;

  int n_cmp;
  int n_err;
  logic [1:0] exp_q[$];

  nucleotide_encoder dut (
    .i_w_clk      (clk),
    .i_w_reset    (rst),
    .i_w_A        (btn_a),
    .i_w_G        (btn_g),
    .i_w_C        (btn_c),
    .i_w_T        (btn_t),
    .i_w_ready    (ready),
    .o_r_valid    (valid),
    .o_r_code     (code),
    .o_r_error    (error),
    .o_r_overflow (overflow),
    .o_r_count    (count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  // checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard: a pop happens on the next rising edge when valid&ready
  always @(negedge clk) begin
    if (!rst && valid && ready) begin
      if (exp_q.size() == 0) begin
        check("pop_unexpected", 32'(code), 32'hFF);
      end else begin
        check("pop_code", 32'(code), 32'(exp_q.pop_front()));
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input logic [1:0] c, input logic v);
    case (c)
      2'b00: btn_a = v;
      2'b01: btn_c = v;
      2'b10: btn_g = v;
      default: btn_t = v;
    endcase
  endtask

  task automatic press_one(input logic [1:0] c, input bit expect_push);
    set_btn(c, 1'b1);
    if (expect_push) exp_q.push_back(c);
    repeat (2) tick();
    set_btn(c, 1'b0);
    repeat (4) tick();
  endtask

  task automatic wait_drain();
    ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (count == 3'd0) break;
      tick();
    end
    check("drain_done", 32'(count), 32'd0);
    ready = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, 32'(valid), 32'd0);
    check({tag, "_code"}, 32'(code), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
    check({tag, "_count"}, 32'(count), 32'd0);
  endtask

  initial begin
    int errs;
    n_cmp = 0;
    n_err = 0;
    btn_a = 0; btn_g = 0; btn_c = 0; btn_t = 0;
    ready = 0;
    rst = 1;
    repeat (3) tick();
    check_idle_outputs("reset");
    rst = 0;
    repeat (3) tick();

    // Held G with ready=1: one symbol, valid 3 edges after press
    ready = 1;
    btn_g = 1;
    exp_q.push_back(2'b10);
    tick();
    check("g_lat_e1_valid", 32'(valid), 32'd0);
    tick();
    check("g_lat_e2_valid", 32'(valid), 32'd0);
    tick();
    check("g_lat_e3_valid", 32'(valid), 32'd1);
    check("g_lat_e3_count", 32'(count), 32'd1);
    check("g_lat_e3_code", 32'(code), 32'd2);
    tick();
    check("g_lat_e4_count", 32'(count), 32'd0);
    errs = 0;
    repeat (6) begin
      tick();
      if (count != 3'd0 || error) errs++;
    end
    check("g_held_no_repeat", 32'(errs), 32'd0);
    btn_g = 0;
    repeat (4) tick();
    ready = 0;

    // Separate presses G,G,T,C then drain in consecutive cycles
    press_one(2'b10, 1);
    press_one(2'b10, 1);
    press_one(2'b11, 1);
    press_one(2'b01, 1);
    check("fill4_count", 32'(count), 32'd4);
    check("fill4_head", 32'(code), 32'd2);
    check("fill4_overflow", 32'(overflow), 32'd0);
    ready = 1;
    tick();
    check("drain_c3", 32'(count), 32'd3);
    tick();
    check("drain_c2", 32'(count), 32'd2);
    tick();
    check("drain_c1", 32'(count), 32'd1);
    tick();
    check("drain_c0", 32'(count), 32'd0);
    check("drain_empty_code", 32'(code), 32'd0);
    tick();
    check("empty_ready_count", 32'(count), 32'd0);
    ready = 0;

    // Overflow: fill 4, press A -> dropped
    press_one(2'b01, 1);
    press_one(2'b11, 1);
    press_one(2'b10, 1);
    press_one(2'b01, 1);
    press_one(2'b00, 0);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd4);
    wait_drain();
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Illegal: A and C in the same cycle
    btn_a = 1; btn_c = 1;
    errs = 0;
    repeat (6) begin
      tick();
      if (error) errs++;
    end
    check("ac_err_pulses", 32'(errs), 32'd1);
    check("ac_count", 32'(count), 32'd0);
    btn_a = 0; btn_c = 0;
    repeat (4) tick();

    // Illegal: T while C held (C itself is a legal push)
    btn_c = 1;
    exp_q.push_back(2'b01);
    repeat (5) tick();
    check("c_held_count", 32'(count), 32'd1);
    btn_t = 1;
    errs = 0;
    repeat (6) begin
      tick();
      if (error) errs++;
    end
    check("tc_err_pulses", 32'(errs), 32'd1);
    check("tc_count", 32'(count), 32'd1);
    btn_t = 0; btn_c = 0;
    repeat (4) tick();
    wait_drain();

    // Reset mid-stream with count=3 and T held
    press_one(2'b00, 1);
    press_one(2'b01, 1);
    press_one(2'b10, 1);
    check("pre_rst_count", 32'(count), 32'd3);
    btn_t = 1;
    tick();
    #2;
    rst = 1;
    exp_q.delete();
    #1;
    check_idle_outputs("async_rst");
    repeat (2) tick();
    rst = 0;
    ready = 1;
    errs = 0;
    repeat (6) begin
      tick();
      if (count != 3'd0 || error) errs++;
    end
    check("held_thru_rst_no_evt", 32'(errs), 32'd0);
    btn_t = 0;
    repeat (4) tick();
    ready = 0;
    press_one(2'b11, 1);
    check("t_repress_count", 32'(count), 32'd1);
    check("t_repress_code", 32'(code), 32'd3);
    wait_drain();

    // Full FIFO: pop and G push on the same edge
    press_one(2'b00, 1);
    press_one(2'b01, 1);
    press_one(2'b11, 1);
    press_one(2'b00, 1);
    btn_g = 1;
    exp_q.push_back(2'b10);
    tick();
    tick();
    ready = 1;
    tick();
    ready = 0;
    check("full_pp_count", 32'(count), 32'd4);
    check("full_pp_overflow", 32'(overflow), 32'd0);
    btn_g = 0;
    repeat (4) tick();
    wait_drain();
    repeat (2) tick();

    check("scoreboard_left", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
